// File: rtl/layer_progress_sequencer_l10_pkg.sv
// Shared types and default sizing for the L10..L17 layer progress sequencer.
package layer_seq_pkg;

  localparam int DEF_NUM_STAGES = 7;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_FILL_ROWS  = 3;
  localparam int DEF_TOTAL_ROWS = 56;

  typedef logic [DEF_CNT_W-1:0] row_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/layer_progress_sequencer_l10_if.sv
// Pulse/status bundle between the layer datapaths (master) and the sequencer (slave).
// Handshake: every input is a one-cycle valid pulse with no ready; the sequencer
// always samples it on the next rising edge. Pulses that arrive when the target
// counter cannot accept them are dropped and latched into seq_err.
interface layer_progress_sequencer_l10_if
  import layer_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int CNT_W      = DEF_CNT_W
);

  logic                                 layer_start;
  logic [NUM_STAGES-1:0]                row_done;
  logic                                 l17_row_done;
  logic [NUM_STAGES-1:0]                flags;
  logic                                 finish_layer;
  logic                                 Reg_cond;
  logic                                 frame_done;
  logic                                 busy;
  logic                                 seq_err;
  // debug visibility
  seq_state_e                           state;
  logic [NUM_STAGES-1:0][CNT_W-1:0]     stage_count;
  logic [CNT_W-1:0]                     l17_count;
  logic                                 l17_fill;

  modport master (
    output layer_start, row_done, l17_row_done,
    input  flags, finish_layer, Reg_cond, frame_done, busy, seq_err,
    input  state, stage_count, l17_count, l17_fill
  );

  modport slave (
    input  layer_start, row_done, l17_row_done,
    output flags, finish_layer, Reg_cond, frame_done, busy, seq_err,
    output state, stage_count, l17_count, l17_fill
  );

endinterface

// File: rtl/layer_progress_sequencer_l10_stage_row_counter.sv
// Saturating per-layer row counter with sticky fill detection.
// fill_reached and full are the values that take effect at the next clock edge,
// so the parent can register them without adding a cycle of latency.
module stage_row_counter
  import layer_seq_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FILL_ROWS  = DEF_FILL_ROWS,
  parameter int TOTAL_ROWS = DEF_TOTAL_ROWS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             pulse,
  output logic [CNT_W-1:0] count,
  output logic             fill_reached,
  output logic             full,
  output logic             overflow_err
);

  localparam logic [CNT_W-1:0] FILL_C  = CNT_W'(FILL_ROWS);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL_ROWS);

  logic [CNT_W-1:0] count_q, count_d;
  logic             fill_q, fill_d;
  logic             at_max, bump;

  assign at_max = (count_q == TOTAL_C);
  assign bump   = pulse && enable && !at_max;

  // next count and sticky fill; clear wins over any pulse
  always_comb begin
    count_d = count_q;
    fill_d  = fill_q;
    if (clear) begin
      count_d = '0;
      fill_d  = 1'b0;
    end else if (bump) begin
      count_d = count_q + 1'b1;
      fill_d  = fill_q | (count_d == FILL_C);
    end
  end

  // counter state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      fill_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      fill_q  <= fill_d;
    end
  end

  assign count        = count_q;
  assign fill_reached = fill_d;
  assign full         = (count_d == TOTAL_C);
  assign overflow_err = pulse && (!enable || at_max);

endmodule

// File: rtl/layer_progress_sequencer_l10.sv
// Layer progress sequencer: counts rows from L10..L16, enables each successor
// once its predecessor has filled its kernel window, and drives L17 until drain.
module layer_progress_sequencer_l10
  import layer_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FILL_ROWS  = DEF_FILL_ROWS,
  parameter int TOTAL_ROWS = DEF_TOTAL_ROWS
) (
  input  logic                           clk,
  input  logic                           rst,
  layer_progress_sequencer_l10_if.slave  bus
);

  seq_state_e                       state_q, state_d;
  logic [NUM_STAGES-1:0]            flags_q, stage_en, stage_fill, stage_full, stage_err;
  logic [NUM_STAGES-1:0][CNT_W-1:0] stage_count;
  logic [CNT_W-1:0]                 l17_count;
  logic                             finish_q, reg_cond_q, reg_cond_d, frame_done_q;
  logic                             seq_err_q, seq_err_d;
  logic                             clear_all, l17_fill, l17_full, l17_err;

  assign clear_all = (state_q == ST_IDLE) && bus.layer_start;

  // enable chain: stage 0 runs freely in RUN, each later stage waits on the registered flag before it
  always_comb begin
    stage_en = '0;
    if (state_q == ST_RUN) stage_en = {flags_q[NUM_STAGES-2:0], 1'b1};
  end

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    stage_row_counter #(
      .CNT_W(CNT_W), .FILL_ROWS(FILL_ROWS), .TOTAL_ROWS(TOTAL_ROWS)
    ) u_cnt (
      .clk(clk), .rst(rst), .clear(clear_all), .enable(stage_en[i]),
      .pulse(bus.row_done[i]), .count(stage_count[i]),
      .fill_reached(stage_fill[i]), .full(stage_full[i]), .overflow_err(stage_err[i])
    );
  end

  stage_row_counter #(
    .CNT_W(CNT_W), .FILL_ROWS(FILL_ROWS), .TOTAL_ROWS(TOTAL_ROWS)
  ) u_l17_cnt (
    .clk(clk), .rst(rst), .clear(clear_all), .enable(reg_cond_q),
    .pulse(bus.l17_row_done), .count(l17_count),
    .fill_reached(l17_fill), .full(l17_full), .overflow_err(l17_err)
  );

  // frame FSM next state; completion tests use next-edge counter values to keep 1-cycle latency
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.layer_start) state_d = ST_RUN;
      ST_RUN:   if (&stage_full)     state_d = ST_DRAIN;
      ST_DRAIN: if (l17_full)        state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // L17 enable and sticky protocol error, both evaluated against next-edge values
  always_comb begin
    reg_cond_d = (state_d != ST_IDLE) && stage_fill[NUM_STAGES-1] && !l17_full;
    seq_err_d  = seq_err_q | (|stage_err) | l17_err |
                 (bus.layer_start && (state_q != ST_IDLE));
  end

  // registered state and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      flags_q      <= '0;
      finish_q     <= 1'b0;
      reg_cond_q   <= 1'b0;
      frame_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flags_q      <= stage_fill;
      finish_q     <= (state_d == ST_DRAIN);
      reg_cond_q   <= reg_cond_d;
      frame_done_q <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
      seq_err_q    <= seq_err_d;
    end
  end

  assign bus.flags        = flags_q;
  assign bus.finish_layer = finish_q;
  assign bus.Reg_cond     = reg_cond_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.seq_err      = seq_err_q;
  assign bus.state        = state_q;
  assign bus.stage_count  = stage_count;
  assign bus.l17_count    = l17_count;
  assign bus.l17_fill     = l17_fill;

endmodule

// File: tb/tb_layer_progress_sequencer_l10.sv
// Directed bench for the layer progress sequencer (FILL_ROWS=2, TOTAL_ROWS=4).
module tb_layer_progress_sequencer_l10;
  import layer_seq_pkg::*;

  localparam int NS    = 7;
  localparam int CW    = 8;
  localparam int FILL  = 2;
  localparam int TOTAL = 4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  layer_progress_sequencer_l10_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus();

  layer_progress_sequencer_l10 #(
    .NUM_STAGES(NS), .CNT_W(CW), .FILL_ROWS(FILL), .TOTAL_ROWS(TOTAL)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // {flags[6:0], finish_layer, Reg_cond, frame_done, busy, seq_err}
  wire [NS+4:0] outs = {bus.flags, bus.finish_layer, bus.Reg_cond,
                        bus.frame_done, bus.busy, bus.seq_err};

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.layer_start  = 1'b0;
    bus.row_done     = '0;
    bus.l17_row_done = 1'b0;
  endtask

  task automatic pulse(input logic start, input logic [NS-1:0] rows, input logic l17);
    bus.layer_start  = start;
    bus.row_done     = rows;
    bus.l17_row_done = l17;
    step();
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (3) step();
    n_checks++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_held_outs: got %h expected %h", outs, 12'h000);
    end
    n_checks++;
    if (bus.state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_held_state: got %0d expected %0d", bus.state, ST_IDLE);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_release_outs: got %h expected %h", outs, 12'h000);
    end
    n_checks++;
    if (bus.stage_count !== '0 || bus.l17_count !== '0) begin
      n_fail++; $display("FAIL reset_counters: got %h/%h expected 0/0", bus.stage_count, bus.l17_count);
    end
  endtask

  task automatic test_fill_flag();
    do_reset();
    pulse(1'b1, '0, 1'b0);
    n_checks++;
    if (outs !== 12'h002 || bus.state !== ST_RUN) begin
      n_fail++; $display("FAIL start_run: got %h st %0d expected %h st %0d", outs, bus.state, 12'h002, ST_RUN);
    end
    pulse(1'b0, 7'h01, 1'b0);
    n_checks++;
    if (bus.flags !== 7'h00 || bus.stage_count[0] !== 8'd1) begin
      n_fail++; $display("FAIL fill_row1: got flags %h cnt %0d expected 00 cnt 1", bus.flags, bus.stage_count[0]);
    end
    pulse(1'b0, 7'h01, 1'b0);
    n_checks++;
    if (bus.flags !== 7'h01 || bus.stage_count[0] !== 8'd2) begin
      n_fail++; $display("FAIL fill_row2: got flags %h cnt %0d expected 01 cnt 2", bus.flags, bus.stage_count[0]);
    end
    pulse(1'b0, 7'h01, 1'b0);
    n_checks++;
    if (outs !== {7'h01, 5'b00010} || bus.stage_count[0] !== 8'd3) begin
      n_fail++; $display("FAIL fill_row3: got %h cnt %0d expected %h cnt 3", outs, bus.stage_count[0], {7'h01, 5'b00010});
    end
  endtask

  // stage s emits rows on steps 2s..2s+3; its flag shows after step 2s+1
  task automatic test_pipeline();
    logic [NS-1:0]  mask;
    logic [NS-1:0]  exp_flags;
    logic [NS+4:0]  exp;
    do_reset();
    pulse(1'b1, '0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      mask      = '0;
      exp_flags = '0;
      for (int s = 0; s < NS; s++) begin
        if (k >= 2*s && k <= 2*s + 3) mask[s] = 1'b1;
        if (k >= 2*s + 1) exp_flags[s] = 1'b1;
      end
      pulse(1'b0, mask, 1'b0);
      exp = {exp_flags, (k >= 15), (k >= 13), 1'b0, 1'b1, 1'b0};
      n_checks++;
      if (outs !== exp) begin
        n_fail++; $display("FAIL pipeline_step%0d: got %h expected %h", k, outs, exp);
      end
    end
    n_checks++;
    if (bus.state !== ST_DRAIN || bus.stage_count !== {NS{8'd4}}) begin
      n_fail++; $display("FAIL pipeline_end: got st %0d cnt %h expected st %0d all 04", bus.state, bus.stage_count, ST_DRAIN);
    end
  endtask

  // continues from DRAIN left by test_pipeline
  task automatic test_drain();
    for (int j = 0; j < 4; j++) begin
      pulse(1'b0, '0, 1'b1);
      if (j < 3) begin
        n_checks++;
        if (outs !== {7'h7F, 5'b11010} || bus.l17_count !== 8'(j + 1)) begin
          n_fail++; $display("FAIL drain_row%0d: got %h cnt %0d expected %h cnt %0d", j, outs, bus.l17_count, {7'h7F, 5'b11010}, j + 1);
        end
      end else begin
        n_checks++;
        if (outs !== {7'h7F, 5'b00100} || bus.state !== ST_IDLE) begin
          n_fail++; $display("FAIL drain_done: got %h st %0d expected %h st %0d", outs, bus.state, {7'h7F, 5'b00100}, ST_IDLE);
        end
      end
    end
    step();
    n_checks++;
    if (outs !== {7'h7F, 5'b00000}) begin
      n_fail++; $display("FAIL frame_done_width: got %h expected %h", outs, {7'h7F, 5'b00000});
    end
  endtask

  task automatic test_errors();
    // row pulse in IDLE
    do_reset();
    pulse(1'b0, 7'h01, 1'b0);
    n_checks++;
    if (outs !== 12'h001 || bus.stage_count[0] !== 8'd0) begin
      n_fail++; $display("FAIL err_idle_row: got %h cnt %0d expected %h cnt 0", outs, bus.stage_count[0], 12'h001);
    end
    // start and row pulse together
    do_reset();
    pulse(1'b1, 7'h01, 1'b0);
    n_checks++;
    if (outs !== 12'h003 || bus.stage_count[0] !== 8'd0 || bus.state !== ST_RUN) begin
      n_fail++; $display("FAIL err_start_row: got %h cnt %0d st %0d expected %h cnt 0 st 1", outs, bus.stage_count[0], bus.state, 12'h003);
    end
    // row on a disabled stage, then held
    do_reset();
    pulse(1'b1, '0, 1'b0);
    pulse(1'b0, 7'h08, 1'b0);
    repeat (3) step();
    n_checks++;
    if (outs !== 12'h003 || bus.stage_count[3] !== 8'd0) begin
      n_fail++; $display("FAIL err_disabled_stage: got %h cnt %0d expected %h cnt 0", outs, bus.stage_count[3], 12'h003);
    end
    // layer_start while running
    do_reset();
    pulse(1'b1, '0, 1'b0);
    pulse(1'b0, 7'h01, 1'b0);
    n_checks++;
    if (bus.seq_err !== 1'b0) begin
      n_fail++; $display("FAIL err_clean_run: got %b expected 0", bus.seq_err);
    end
    pulse(1'b1, '0, 1'b0);
    n_checks++;
    if (bus.seq_err !== 1'b1 || bus.state !== ST_RUN || bus.stage_count[0] !== 8'd1) begin
      n_fail++; $display("FAIL err_start_in_run: got err %b st %0d cnt %0d expected 1 1 1", bus.seq_err, bus.state, bus.stage_count[0]);
    end
    // successor pulse in the same cycle its enabling flag sets
    do_reset();
    pulse(1'b1, '0, 1'b0);
    pulse(1'b0, 7'h01, 1'b0);
    pulse(1'b0, 7'h03, 1'b0);
    n_checks++;
    if (outs !== {7'h01, 5'b00011} || bus.stage_count[0] !== 8'd2 || bus.stage_count[1] !== 8'd0) begin
      n_fail++; $display("FAIL err_same_cycle_flag: got %h c0 %0d c1 %0d expected %h c0 2 c1 0", outs, bus.stage_count[0], bus.stage_count[1], {7'h01, 5'b00011});
    end
    // pulse on a saturated counter
    do_reset();
    pulse(1'b1, '0, 1'b0);
    repeat (4) pulse(1'b0, 7'h01, 1'b0);
    n_checks++;
    if (bus.seq_err !== 1'b0 || bus.stage_count[0] !== 8'd4) begin
      n_fail++; $display("FAIL sat_reach: got err %b cnt %0d expected 0 cnt 4", bus.seq_err, bus.stage_count[0]);
    end
    pulse(1'b0, 7'h01, 1'b0);
    n_checks++;
    if (bus.seq_err !== 1'b1 || bus.stage_count[0] !== 8'd4) begin
      n_fail++; $display("FAIL err_saturated: got err %b cnt %0d expected 1 cnt 4", bus.seq_err, bus.stage_count[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    pulse(1'b1, '0, 1'b0);
    pulse(1'b0, 7'h01, 1'b0);
    pulse(1'b0, 7'h01, 1'b0);
    n_checks++;
    if (bus.stage_count[0] !== 8'd2 || outs !== {7'h01, 5'b00010}) begin
      n_fail++; $display("FAIL mid_pre: got %h cnt %0d expected %h cnt 2", outs, bus.stage_count[0], {7'h01, 5'b00010});
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (outs !== '0 || bus.stage_count !== '0 || bus.state !== ST_IDLE) begin
      n_fail++; $display("FAIL mid_async_reset: got %h cnt %h st %0d expected 0 0 0", outs, bus.stage_count, bus.state);
    end
    step();
    rst = 1'b1;
    step();
    pulse(1'b1, '0, 1'b0);
    pulse(1'b0, 7'h01, 1'b0);
    n_checks++;
    if (outs !== 12'h002 || bus.stage_count[0] !== 8'd1) begin
      n_fail++; $display("FAIL mid_restart: got %h cnt %0d expected %h cnt 1", outs, bus.stage_count[0], 12'h002);
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_fill_flag();
    test_pipeline();
    test_drain();
    test_errors();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
